unified_cache_mem_responder: RTL



---
 rtl/unified_cache_mem_responder_pkg.sv | 56 +++++
 rtl/unified_cache_mem_responder_if.sv | 39 +++
 rtl/unified_cache_mem_responder_storage.sv | 61 ++++++
 rtl/unified_cache_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/unified_cache_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// unified_cache_mem_responder_pkg
//
// Shared definitions for the unified cache memory-side responder.
//
// Contents:
//   - Packet field positions of the cache to-mem / from-mem packet.
//     Layout, LSB first: data, address, port number, is-write flag, valid flag.
//   - Responder FSM state encodings (2 bits).
//   - Seed for the optional latency-jitter LFSR.
//   - Helpers: a packet field mask builder and the LFSR next-state function.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package unified_cache_mem_responder_pkg;

  // Packet field positions (bit indices inside the packet vector)
  localparam int UNIFIED_CACHE_PACKET_DATA_POS_LO     = 0;
  localparam int UNIFIED_CACHE_PACKET_DATA_POS_HI     = 31;
  localparam int UNIFIED_CACHE_PACKET_ADDR_POS_LO     = 32;
  localparam int UNIFIED_CACHE_PACKET_ADDR_POS_HI     = 63;
  localparam int UNIFIED_CACHE_PACKET_PORT_NUM_POS_LO = 64;
  localparam int UNIFIED_CACHE_PACKET_PORT_NUM_POS_HI = 67;
  localparam int UNIFIED_CACHE_PACKET_IS_WRITE_POS    = 68;
  localparam int UNIFIED_CACHE_PACKET_VALID_POS       = 69;
  localparam int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS   = 70;

  // Responder FSM state encodings
  typedef enum logic [1:0] {
    MEM_RESPONDER_STATE_IDLE    = 2'b00,
    MEM_RESPONDER_STATE_WAIT    = 2'b01,
    MEM_RESPONDER_STATE_RESPOND = 2'b10
  } mem_responder_state_e;

  // Reset seed of the latency-jitter LFSR
  localparam logic [15:0] MEM_RESPONDER_JITTER_LFSR_SEED = 16'hACE1;

  // Builds a packet-wide mask with ones in bits lo..hi.
  function automatic logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] packet_field_mask(
    input int hi,
    input int lo
  );
    logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] mask;
    mask = '0;
    for (int i = 0; i < UNIFIED_CACHE_PACKET_WIDTH_IN_BITS; i++) begin
      mask[i] = (i >= lo) && (i <= hi);
    end
    return mask;
  endfunction

  // 16-bit Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10).
  function automatic logic [15:0] mem_responder_lfsr_next(input logic [15:0] state);
    return {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  endfunction

endpackage

// File: rtl/unified_cache_mem_responder_if.sv
// ---------------------------------------------------------------------------
// unified_cache_mem_responder_if
//
// Packet handshake between the unified cache (to-mem / from-mem ports) and
// the memory responder. Signal names are from the responder's point of view.
//
// Signals:
//   request_packet_in       cache -> mem  request packet (miss or writeback)
//   request_packet_ack_out  mem -> cache  single-cycle accept pulse
//   return_packet_out       mem -> cache  fill packet
//   return_packet_ack_in    cache -> mem  cache accepted the fill
//
// Modports:
//   master  cache side (drives requests, consumes fills)
//   slave   responder side
// ---------------------------------------------------------------------------
interface unified_cache_mem_responder_if;
  import unified_cache_mem_responder_pkg::*;

  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] request_packet_in;
  logic                                          request_packet_ack_out;
  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] return_packet_out;
  logic                                          return_packet_ack_in;

  modport master (
    output request_packet_in,
    input  request_packet_ack_out,
    input  return_packet_out,
    output return_packet_ack_in
  );

  modport slave (
    input  request_packet_in,
    output request_packet_ack_out,
    output return_packet_out,
    input  return_packet_ack_in
  );

endinterface

// File: rtl/unified_cache_mem_responder_storage.sv
// ---------------------------------------------------------------------------
// unified_cache_mem_storage
//
// Block-granular backing store: NUM_BLOCK entries of DATA_WIDTH bits, one
// synchronous write port and one synchronous read port. A read and a write
// to the same index in the same cycle return the new (write) data. The read
// data register only updates when a read is enabled, so it holds the last
// read value for as long as the consumer needs it. Contents are not cleared
// by any reset.
//
// Ports:
//   clk_in       clock
//   wr_en_in     write enable
//   wr_index_in  write block index
//   wr_data_in   write data
//   rd_en_in     read enable
//   rd_index_in  read block index
//   rd_data_out  registered read data (valid the cycle after rd_en_in)
// ---------------------------------------------------------------------------
module unified_cache_mem_storage #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BLOCK  = 1024,
  parameter int INDEX_W    = $clog2(NUM_BLOCK)
) (
  input  logic                  clk_in,
  input  logic                  wr_en_in,
  input  logic [INDEX_W-1:0]    wr_index_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  rd_en_in,
  input  logic [INDEX_W-1:0]    rd_index_in,
  output logic [DATA_WIDTH-1:0] rd_data_out
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_BLOCK];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Read-data next value: write-first bypass when both ports hit one index,
  // otherwise the array contents; hold when no read is requested.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_in) begin
      if (wr_en_in && (wr_index_in == rd_index_in)) begin
        rd_data_d = wr_data_in;
      end else begin
        rd_data_d = mem_q[rd_index_in];
      end
    end
  end

  // Array write and read-data register; no reset so the store maps to RAM.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_q[wr_index_in] <= wr_data_in;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data_out = rd_data_q;

endmodule

// File: rtl/unified_cache_mem_responder.sv
// ---------------------------------------------------------------------------
// unified_cache_mem_responder
//
// Memory-side endpoint of the unified cache packet interface. Accepts miss
// (read) and writeback (write) packets, keeps a block-granular backing store,
// and answers reads with a fill packet after a programmable latency. Only one
// read is outstanding at a time; new requests are simply not acked until the
// responder is idle again.
//
// Parameters:
//   BLOCK_SIZE_IN_BYTES  bytes per block (data field = 8*BLOCK_SIZE_IN_BYTES)
//   NUM_BLOCK            store depth in blocks, power of two
//   LATENCY              cycles from request ack to return valid, 1..255
//
// Ports:
//   clk_in    clock
//   reset_in  synchronous, active-high reset
//   mem_if    slave side of unified_cache_mem_responder_if
//             (request_packet_in, request_packet_ack_out,
//              return_packet_out, return_packet_ack_in)
//
// Build option:
//   UNIFIED_CACHE_MEM_RESPONDER_JITTER_EN  when defined, a 16-bit LFSR adds
//   0..3 extra cycles to each read's latency. When undefined the latency is
//   exactly LATENCY and no LFSR exists.
// ---------------------------------------------------------------------------
module unified_cache_mem_responder
  import unified_cache_mem_responder_pkg::*;
#(
  parameter int BLOCK_SIZE_IN_BYTES = 4,
  parameter int NUM_BLOCK           = 1024,
  parameter int LATENCY             = 4
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  unified_cache_mem_responder_if.slave  mem_if
);

  localparam int PKT_W    = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int DATA_W   = 8 * BLOCK_SIZE_IN_BYTES;
  localparam int OFFSET_W = $clog2(BLOCK_SIZE_IN_BYTES);
  localparam int INDEX_W  = $clog2(NUM_BLOCK);
  // Wide enough for LATENCY-1 plus up to 3 jitter cycles.
  localparam int CNT_W    = 9;
  localparam int INDEX_LO = UNIFIED_CACHE_PACKET_ADDR_POS_LO + OFFSET_W;

  localparam logic [PKT_W-1:0] DATA_MASK =
    packet_field_mask(UNIFIED_CACHE_PACKET_DATA_POS_HI, UNIFIED_CACHE_PACKET_DATA_POS_LO);
  localparam logic [PKT_W-1:0] IS_WRITE_MASK =
    packet_field_mask(UNIFIED_CACHE_PACKET_IS_WRITE_POS, UNIFIED_CACHE_PACKET_IS_WRITE_POS);
  localparam logic [PKT_W-1:0] VALID_MASK =
    packet_field_mask(UNIFIED_CACHE_PACKET_VALID_POS, UNIFIED_CACHE_PACKET_VALID_POS);

  mem_responder_state_e state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_ack_q, req_ack_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [PKT_W-1:0]     req_pkt_q, req_pkt_d;

`ifdef UNIFIED_CACHE_MEM_RESPONDER_JITTER_EN
  logic [15:0]          lfsr_q, lfsr_d;
`endif

  logic [PKT_W-1:0]     req_pkt;
  logic                 req_valid;
  logic                 req_is_write;
  logic [CNT_W-1:0]     latency_load;

  logic                 store_wr_en;
  logic                 store_rd_en;
  logic [INDEX_W-1:0]   store_wr_index;
  logic [INDEX_W-1:0]   store_rd_index;
  logic [DATA_W-1:0]    store_wr_data;
  logic [DATA_W-1:0]    store_rd_data;
  logic [PKT_W-1:0]     resp_pkt;

  assign req_pkt      = mem_if.request_packet_in;
  assign req_valid    = req_pkt[UNIFIED_CACHE_PACKET_VALID_POS];
  assign req_is_write = req_pkt[UNIFIED_CACHE_PACKET_IS_WRITE_POS];

  // Upper address bits are dropped here, so addresses alias modulo the store.
  assign store_wr_index = req_pkt[INDEX_LO +: INDEX_W];
  assign store_wr_data  = req_pkt[UNIFIED_CACHE_PACKET_DATA_POS_LO +: DATA_W];
  assign store_rd_index = req_pkt_q[INDEX_LO +: INDEX_W];

`ifdef UNIFIED_CACHE_MEM_RESPONDER_JITTER_EN
  assign latency_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign latency_load = CNT_W'(LATENCY - 1);
`endif

  unified_cache_mem_storage #(
    .DATA_WIDTH (DATA_W),
    .NUM_BLOCK  (NUM_BLOCK),
    .INDEX_W    (INDEX_W)
  ) u_storage (
    .clk_in      (clk_in),
    .wr_en_in    (store_wr_en),
    .wr_index_in (store_wr_index),
    .wr_data_in  (store_wr_data),
    .rd_en_in    (store_rd_en),
    .rd_index_in (store_rd_index),
    .rd_data_out (store_rd_data)
  );

  // Next-state logic. A request is accepted only in IDLE and only while no
  // ack is already being driven, so a requester that keeps the same packet up
  // through its ack cycle is not accepted twice. Writes commit at the accept
  // edge, which guarantees any later read sees them. The store is read at the
  // edge leaving WAIT; its registered output then holds through RESPOND.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ack_d    = 1'b0;
    resp_valid_d = resp_valid_q;
    req_pkt_d    = req_pkt_q;
    store_wr_en  = 1'b0;
    store_rd_en  = 1'b0;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_JITTER_EN
    lfsr_d       = lfsr_q;
`endif

    case (state_q)
      MEM_RESPONDER_STATE_IDLE: begin
        if (req_valid && !req_ack_q) begin
          req_ack_d = 1'b1;
          if (req_is_write) begin
            store_wr_en = 1'b1;
          end else begin
            state_d   = MEM_RESPONDER_STATE_WAIT;
            cnt_d     = latency_load;
            req_pkt_d = req_pkt;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_JITTER_EN
            lfsr_d    = mem_responder_lfsr_next(lfsr_q);
`endif
          end
        end
      end

      MEM_RESPONDER_STATE_WAIT: begin
        if (cnt_q == '0) begin
          store_rd_en  = 1'b1;
          state_d      = MEM_RESPONDER_STATE_RESPOND;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      MEM_RESPONDER_STATE_RESPOND: begin
        if (mem_if.return_packet_ack_in) begin
          state_d      = MEM_RESPONDER_STATE_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = MEM_RESPONDER_STATE_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset. Reset drops any in-flight read;
  // writes already in the store are untouched.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= MEM_RESPONDER_STATE_IDLE;
      cnt_q        <= '0;
      req_ack_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      req_pkt_q    <= '0;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_JITTER_EN
      lfsr_q       <= MEM_RESPONDER_JITTER_LFSR_SEED;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ack_q    <= req_ack_d;
      resp_valid_q <= resp_valid_d;
      req_pkt_q    <= req_pkt_d;
`ifdef UNIFIED_CACHE_MEM_RESPONDER_JITTER_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  // Fill packet: the latched request with its data replaced by store data,
  // is-write cleared and valid set. Forced to all zeros outside RESPOND.
  always_comb begin
    resp_pkt = (req_pkt_q & ~(DATA_MASK | IS_WRITE_MASK)) | VALID_MASK |
               (PKT_W'(store_rd_data) << UNIFIED_CACHE_PACKET_DATA_POS_LO);
  end

  assign mem_if.request_packet_ack_out = req_ack_q;
  assign mem_if.return_packet_out      = resp_valid_q ? resp_pkt : '0;

endmodule
